// File: rtl/bcd_time_pkg.sv
// Shared types, limits and helpers for the BCD time-of-day counter.
package bcd_time_pkg;

   localparam int BCD_W = 4;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] units;
   } bcd_pair_t;

   localparam bcd_pair_t SEC_MAX  = '{tens: 4'd5, units: 4'd9};
   localparam bcd_pair_t MIN_MAX  = '{tens: 4'd5, units: 4'd9};
   localparam bcd_pair_t HOUR_MAX = '{tens: 4'd2, units: 4'd3};

   // BCD ordering matches binary ordering of the packed pair once both digits are <= 9.
   function automatic logic pair_valid(input bcd_pair_t p, input bcd_pair_t max_val);
      return (p.units <= 4'd9) && (p.tens <= 4'd9) &&
             ({p.tens, p.units} <= {max_val.tens, max_val.units});
   endfunction

endpackage

// File: rtl/bcd_time_counter_pair.sv
// Two-digit BCD modulo-N counter with synchronous load and combinational carry.
module bcd_digit_pair
   import bcd_time_pkg::*;
#(
   parameter int N = 60
) (
   input  logic      clk1,
   input  logic      reset,
   input  logic      inc,
   input  logic      load,
   input  bcd_pair_t load_val,
   output bcd_pair_t value,
   output bcd_pair_t nxt,
   output logic      carry_out
);

   localparam bcd_pair_t MAX_VAL = '{tens: BCD_W'((N - 1) / 10), units: BCD_W'((N - 1) % 10)};

   logic at_max;

   assign at_max    = (value == MAX_VAL);
   assign carry_out = inc && at_max;

   always_comb begin
      nxt = value;
      if (load) begin
         nxt = load_val;
      end else if (inc) begin
         if (at_max) begin
            nxt = '0;
         end else if (value.units == 4'd9) begin
            nxt.tens  = value.tens + 4'd1;
            nxt.units = '0;
         end else begin
            nxt.units = value.units + 4'd1;
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (reset) value <= '0;
      else       value <= nxt;
   end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD clock with 1 Hz prescaler, load/set buttons and an optional alarm
// (alarm logic present only when BCD_TIME_ALARM_EN is defined).
module bcd_time_counter
   import bcd_time_pkg::*;
#(
   parameter int DIV   = 50000000,
   parameter int CNT_W = 26
) (
   input  logic        clk1,
   input  logic        reset,
   input  logic        run,
   input  logic        load,
   input  logic [23:0] set_time,
   input  logic        inc_min,
   input  logic        inc_hour,
   input  logic [15:0] alarm_time,
   input  logic        alarm_arm,
   input  logic        alarm_ack,
   output logic [3:0]  sec_chuc,
   output logic [3:0]  sec_dv,
   output logic [3:0]  min_chuc,
   output logic [3:0]  min_dv,
   output logic [3:0]  hour_chuc,
   output logic [3:0]  hour_dv,
   output logic        tick_1hz,
   output logic        load_err,
   output logic        alarm_ring
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt, cnt_nxt;
   bcd_pair_t set_sec, set_min, set_hour;
   bcd_pair_t sec_val, min_val, hour_val, sec_nxt, min_nxt, hour_nxt;
   logic      sec_carry, min_carry, hour_carry;
   logic      load_ok, inc_any, at_last, advance;

   assign set_hour = set_time[23:16];
   assign set_min  = set_time[15:8];
   assign set_sec  = set_time[7:0];

   assign load_ok = load && pair_valid(set_sec, SEC_MAX) && pair_valid(set_min, MIN_MAX) &&
                    pair_valid(set_hour, HOUR_MAX);
   assign inc_any = inc_min | inc_hour;
   assign at_last = run && (cnt == CNT_LAST);
   assign advance = at_last && !load && !inc_any;

   // A button press parks the prescaler at its last count so the pending second is not lost.
   always_comb begin
      cnt_nxt = cnt;
      if (load_ok) begin
         cnt_nxt = '0;
      end else if (run) begin
         if (cnt != CNT_LAST)          cnt_nxt = cnt + 1'b1;
         else if (load || !inc_any)    cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         cnt      <= '0;
         tick_1hz <= 1'b0;
         load_err <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         tick_1hz <= advance;
         load_err <= load && !load_ok;
      end
   end

   bcd_digit_pair #(.N(60)) u_sec (
      .clk1      (clk1),
      .reset     (reset),
      .inc       (advance),
      .load      (load_ok | (inc_min && !load)),
      .load_val  (load_ok ? set_sec : bcd_pair_t'('0)),
      .value     (sec_val),
      .nxt       (sec_nxt),
      .carry_out (sec_carry)
   );

   bcd_digit_pair #(.N(60)) u_min (
      .clk1      (clk1),
      .reset     (reset),
      .inc       ((inc_min && !load) | sec_carry),
      .load      (load_ok),
      .load_val  (set_min),
      .value     (min_val),
      .nxt       (min_nxt),
      .carry_out (min_carry)
   );

   // Only the seconds-driven rollover carries into hours; a manual minute wrap does not.
   bcd_digit_pair #(.N(24)) u_hour (
      .clk1      (clk1),
      .reset     (reset),
      .inc       ((inc_hour && !load) | (min_carry && advance)),
      .load      (load_ok),
      .load_val  (set_hour),
      .value     (hour_val),
      .nxt       (hour_nxt),
      .carry_out (hour_carry)
   );

   assign sec_chuc  = sec_val.tens;
   assign sec_dv    = sec_val.units;
   assign min_chuc  = min_val.tens;
   assign min_dv    = min_val.units;
   assign hour_chuc = hour_val.tens;
   assign hour_dv   = hour_val.units;

   logic unused_carry;
   assign unused_carry = hour_carry;

`ifdef BCD_TIME_ALARM_EN
   logic [5:0] ring_timer;
   logic       ring_q;
   logic       alarm_match;

   assign alarm_match = advance && alarm_arm && ({hour_nxt, min_nxt} == alarm_time) &&
                        (sec_nxt == bcd_pair_t'('0));

   always_ff @(posedge clk1) begin
      if (reset) begin
         ring_q     <= 1'b0;
         ring_timer <= '0;
      end else if (alarm_match) begin
         ring_q     <= 1'b1;
         ring_timer <= 6'd59;
      end else if (ring_q && (alarm_ack || !alarm_arm)) begin
         ring_q     <= 1'b0;
         ring_timer <= '0;
      end else if (ring_q && advance) begin
         ring_timer <= ring_timer - 6'd1;
         if (ring_timer == 6'd1) ring_q <= 1'b0;
      end
   end

   assign alarm_ring = ring_q;
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_time, alarm_arm, alarm_ack, sec_nxt, min_nxt, hour_nxt};
   assign alarm_ring   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: directed scenarios plus random stimulus
// compared each cycle against a seconds-of-day reference model.
module tb_bcd_time_counter;

   localparam int DIV   = 4;
   localparam int CNT_W = 3;
   localparam int DAY   = 86400;

   logic        clk1 = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        load = 1'b0;
   logic [23:0] set_time = '0;
   logic        inc_min = 1'b0;
   logic        inc_hour = 1'b0;
   logic [15:0] alarm_time = '0;
   logic        alarm_arm = 1'b0;
   logic        alarm_ack = 1'b0;
   logic [3:0]  sec_chuc, sec_dv, min_chuc, min_dv, hour_chuc, hour_dv;
   logic        tick_1hz, load_err, alarm_ring;
   logic [23:0] dut_time;

   always #5 clk1 = ~clk1;

   bcd_time_counter #(.DIV(DIV), .CNT_W(CNT_W)) dut (
      .clk1       (clk1),
      .reset      (reset),
      .run        (run),
      .load       (load),
      .set_time   (set_time),
      .inc_min    (inc_min),
      .inc_hour   (inc_hour),
      .alarm_time (alarm_time),
      .alarm_arm  (alarm_arm),
      .alarm_ack  (alarm_ack),
      .sec_chuc   (sec_chuc),
      .sec_dv     (sec_dv),
      .min_chuc   (min_chuc),
      .min_dv     (min_dv),
      .hour_chuc  (hour_chuc),
      .hour_dv    (hour_dv),
      .tick_1hz   (tick_1hz),
      .load_err   (load_err),
      .alarm_ring (alarm_ring)
   );

   assign dut_time = {hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: time as seconds since midnight, prescaler as a plain count.
   int m_t = 0, m_pc = 0, m_timer = 0;
   bit m_tick = 0, m_err = 0, m_ring = 0;

   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int alarm_secs(input logic [15:0] a);
      return (int'(a[15:12]) * 10 + int'(a[11:8])) * 3600 + (int'(a[7:4]) * 10 + int'(a[3:0])) * 60;
   endfunction

   task automatic model_step();
      int  d[6];
      int  h, m, s;
      bit  adv, e;
      adv = 0;
      e   = 0;
      if (reset) begin
         m_t = 0; m_pc = 0; m_timer = 0; m_ring = 0;
      end else begin
         if (load) begin
            for (int i = 0; i < 6; i++) d[i] = int'(set_time[4*i +: 4]);
            h = d[5] * 10 + d[4];
            m = d[3] * 10 + d[2];
            s = d[1] * 10 + d[0];
            if (d[0] <= 9 && d[1] <= 5 && d[2] <= 9 && d[3] <= 5 && d[4] <= 9 && d[5] <= 9 && h <= 23) begin
               m_t  = h * 3600 + m * 60 + s;
               m_pc = 0;
            end else begin
               e = 1;
               if (run) m_pc = (m_pc + 1) % DIV;
            end
         end else if (inc_min || inc_hour) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            s = m_t % 60;
            if (inc_min)  begin m = (m + 1) % 60; s = 0; end
            if (inc_hour) h = (h + 1) % 24;
            m_t = h * 3600 + m * 60 + s;
            if (run && m_pc != DIV - 1) m_pc++;
         end else if (run) begin
            if (m_pc == DIV - 1) begin
               m_pc = 0;
               m_t  = (m_t + 1) % DAY;
               adv  = 1;
            end else begin
               m_pc++;
            end
         end
`ifdef BCD_TIME_ALARM_EN
         if (adv && alarm_arm && m_t == alarm_secs(alarm_time)) begin
            m_ring = 1; m_timer = 59;
         end else if (m_ring && (alarm_ack || !alarm_arm)) begin
            m_ring = 0; m_timer = 0;
         end else if (m_ring && adv) begin
            m_timer--;
            if (m_timer == 0) m_ring = 0;
         end
`endif
      end
      m_tick = reset ? 1'b0 : adv;
      m_err  = reset ? 1'b0 : e;
   endtask

   task automatic cyc();
      @(posedge clk1);
      model_step();
      #1;
      check("time", 32'(dut_time), 32'(to_bcd(m_t)));
      check("tick", 32'(tick_1hz), 32'(m_tick));
      check("load_err", 32'(load_err), 32'(m_err));
      check("alarm_ring", 32'(alarm_ring), 32'(m_ring));
      load      = 1'b0;
      inc_min   = 1'b0;
      inc_hour  = 1'b0;
      alarm_ack = 1'b0;
   endtask

   task automatic do_load(input logic [23:0] v);
      set_time = v;
      load     = 1'b1;
      cyc();
   endtask

   int          a_secs;
   logic [23:0] tmp;

   initial begin
      // Reset then free-run: ticks every DIV cycles.
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      check("reset_time", 32'(dut_time), 32'h0);
      run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         check("t1_tick_pattern", 32'(tick_1hz), 32'((i % 4) == 3));
      end
      check("t1_time", 32'(dut_time), 32'h000003);

      // Full-day rollover.
      do_load(24'h235958);
      for (int i = 0; i < 4; i++) cyc();
      check("roll_235959", 32'(dut_time), 32'h235959);
      for (int i = 0; i < 4; i++) cyc();
      check("roll_000000", 32'(dut_time), 32'h000000);

      // Rejected load.
      tmp = dut_time;
      do_load(24'h245959);
      check("bad_load_err", 32'(load_err), 32'h1);
      check("bad_load_keep", 32'(dut_time), 32'(tmp));
      cyc();
      check("bad_load_pulse", 32'(load_err), 32'h0);
      do_load(24'h006000);
      check("bad_min_err", 32'(load_err), 32'h1);

      // Set buttons with time frozen.
      run = 1'b0;
      do_load(24'h125930);
      inc_min = 1'b1;
      cyc();
      check("inc_min_wrap", 32'(dut_time), 32'h120000);
      do_load(24'h231005);
      inc_hour = 1'b1;
      cyc();
      check("inc_hour_wrap", 32'(dut_time), 32'h001005);
      inc_min  = 1'b1;
      inc_hour = 1'b1;
      cyc();
      check("inc_both", 32'(dut_time), 32'h011100);

      // inc_min while the prescaler sits on its last count defers the tick.
      run = 1'b1;
      do_load(24'h000000);
      for (int i = 0; i < 3; i++) cyc();
      inc_min = 1'b1;
      cyc();
      check("defer_no_tick", 32'(tick_1hz), 32'h0);
      check("defer_time", 32'(dut_time), 32'h000100);
      cyc();
      check("defer_tick", 32'(tick_1hz), 32'h1);
      check("defer_sec", 32'(dut_time), 32'h000101);

`ifdef BCD_TIME_ALARM_EN
      alarm_time = 16'h0730;
      alarm_arm  = 1'b1;
      do_load(24'h072959);
      for (int i = 0; i < 4; i++) cyc();
      check("alarm_rise", 32'(alarm_ring), 32'h1);
      alarm_ack = 1'b1;
      cyc();
      check("alarm_ack", 32'(alarm_ring), 32'h0);
      do_load(24'h072959);
      for (int i = 0; i < 4; i++) cyc();
      check("alarm_rise2", 32'(alarm_ring), 32'h1);
      for (int i = 0; i < 58 * DIV; i++) cyc();
      check("alarm_hold58", 32'(alarm_ring), 32'h1);
      for (int i = 0; i < DIV; i++) cyc();
      check("alarm_timeout", 32'(alarm_ring), 32'h0);
      do_load(24'h073000);
      check("alarm_no_load_trig", 32'(alarm_ring), 32'h0);
`endif

      // Random stimulus against the model.
      a_secs     = int'($urandom_range(0, 1439)) * 60;
      tmp        = to_bcd(a_secs);
      alarm_time = tmp[23:8];
      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(0, 799) == 0);
         run       = ($urandom_range(0, 99) < 85);
         alarm_arm = ($urandom_range(0, 19) != 0);
         alarm_ack = ($urandom_range(0, 59) == 0);
         inc_min   = ($urandom_range(0, 29) == 0);
         inc_hour  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) begin
            load = 1'b1;
            case ($urandom_range(0, 2))
               0:       set_time = 24'($urandom());
               1:       set_time = to_bcd(int'($urandom_range(0, DAY - 1)));
               default: set_time = to_bcd((a_secs - int'($urandom_range(1, 3)) + DAY) % DAY);
            endcase
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Timekeeping stage that sits directly upstream of the TM1638 display driver.
- Divides clk1 down to a 1 Hz tick and keeps 24-hour time as six BCD digits (hours, minutes, seconds; tens and units).
- Digit outputs connect one-to-one to the driver's sec/min/hour digit inputs.
- Supports synchronous time load, minute/hour set buttons (pre-debounced pulses) and an optional alarm.

Parameters:
- DIV, 50000000: clk1 cycles per second; minimum 2. Benches use 4.
- CNT_W, 26: prescaler width; must satisfy 2^CNT_W >= DIV.

Ports:
- clk1  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = time advances; 0 = prescaler and time frozen.
- load  in  1  one-cycle pulse; load set_time.
- set_time  in  24  BCD {hour_chuc, hour_dv, min_chuc, min_dv, sec_chuc, sec_dv}, MSB first.
- inc_min  in  1  one-cycle pulse; minutes +1.
- inc_hour  in  1  one-cycle pulse; hours +1.
- alarm_time  in  16  BCD {hh, mm}; used only with the alarm feature.
- alarm_arm  in  1  alarm enable level.
- alarm_ack  in  1  one-cycle pulse; silence the alarm.
- sec_chuc, sec_dv, min_chuc, min_dv, hour_chuc, hour_dv  out  4 each  registered BCD digits.
- tick_1hz  out  1  one-cycle pulse in the cycle the seconds advance.
- load_err  out  1  one-cycle pulse when a load is rejected.
- alarm_ring  out  1  alarm active level.

Behaviour:
- Reset: all digits 0 (00:00:00), prescaler 0, tick_1hz=0, load_err=0, alarm_ring=0, alarm ring-timer 0.
- All outputs are registered. New values are visible in the cycle after the causing edge.
- Prescaler counts 0..DIV-1 while run=1. At DIV-1 it wraps to 0 and a second-advance is issued: seconds +1 and tick_1hz=1 in the same registered update.
- Carry chain:
  - sec 59 -> 00 with a carry into minutes.
  - min 59 -> 00 with a carry into hours.
  - hour 23 -> 00.
  - 23:59:59 -> 00:00:00 in a single update.
- Units wrap 9 -> 0 and increment the tens digit. Tens limits: sec/min 5; hour 2 (units limit 3 when tens is 2).
- Priority per cycle: reset > load > inc_min/inc_hour > second-advance.
- Load:
  - Valid when every digit <= 9, sec/min tens <= 5, and hours <= 23.
  - Valid load: digits take set_time and the prescaler clears to 0. No tick that cycle.
  - Invalid load: digits unchanged, prescaler continues normally, load_err=1 for one cycle.
  - load overrides any simultaneous inc or advance.
- inc_min:
  - Minutes +1, 59 -> 00 with no carry into hours. Seconds cleared to 00.
  - Prescaler unaffected, except when it sits at DIV-1 with run=1: it holds at DIV-1 that cycle, so the advance is deferred one cycle (no tick is lost).
- inc_hour: hours +1, 23 -> 00. Minutes and seconds unchanged. Same deferral rule as inc_min.
- inc_min and inc_hour in the same cycle: both applied independently.
- inc pulses act regardless of run.
- run=0: prescaler holds its value; load and inc still act.
- Digits never leave the legal range, because every update path is validated.

Optional Feature:
- Macro: BCD_TIME_ALARM_EN.
- Defined:
  - On a second-advance whose result equals alarm_time:00 while alarm_arm=1, alarm_ring sets and a 6-bit ring-timer loads 59.
  - The ring-timer decrements on each subsequent tick. alarm_ring clears when the timer reaches 0, on alarm_ack, or when alarm_arm=0, all effective the next cycle.
  - alarm_ack together with a match: the match wins (ring sets).
  - load or inc landing exactly on the alarm time does not trigger the alarm.
- Not defined: alarm_ring is constant 0, alarm inputs are ignored, and no alarm logic is synthesised.

Decomposition:
- Package bcd_time_pkg holds:
  - BCD_W=4.
  - Limit constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23 as BCD pairs.
  - Digit-pair typedef {tens, units}.
  - Validity function for a BCD pair against a maximum.
- One sub-module, bcd_digit_pair: a mod-N two-digit BCD counter with inc, load, load_val and carry_out (combinational carry when inc is asserted at max). It is instantiated three times; N is a parameter (60/60/24).

Test Plan (DIV=4):
- Reset, then run=1 for 12 cycles -> tick_1hz pulses on cycles 4, 8, 12; sec_dv reads 3; all other digits 0.
- Load 23:59:58, run 8 cycles -> reads 23:59:59, then 00:00:00 on the second tick; no intermediate illegal digits.
- Load with set_time hour=24 (h'245959) -> load_err high for exactly one cycle; digits keep their previous value.
- inc_min at 12:59:30 -> 12:00:00; inc_hour at 23:10:05 -> 00:10:05.
- inc_min asserted in the same cycle the prescaler reaches 3 -> minutes update and seconds clear; tick_1hz follows one cycle later and seconds read 01.
- With BCD_TIME_ALARM_EN, alarm 07:30, armed, load 07:29:59 -> alarm_ring rises after the next tick; alarm_ack clears it next cycle; without ack it clears after 59 further ticks.
